// File: rtl/onehot_enc_4to2.sv
// Registered 4-to-2 one-hot encoder with a valid/ready handshake on both sides.
// Recovers {en, a} from decoded select lines and flags codes that are not one-hot.
// A one-entry output register gives full throughput when the consumer keeps up.
// A saturating counter tracks how many accepted codes were multi-hot.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable until that edge.
// in_ready is combinational (!out_valid || out_ready), so a consume and a new
// accept may happen on the same edge.
module onehot_enc_4to2 #(
   parameter bit STRICT = 1'b1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       a_out,
   output logic             en_out,
   output logic             err_out,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic       accept;
   logic [3:0] y_m;
   logic [1:0] a_nxt;
   logic       en_nxt;
   logic       err_nxt;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Mask the code with in_valid so an undriven bus never reaches the encoder.
   assign y_m = in_valid ? y_in : 4'b0000;

   // Encode the masked code. Multi-hot handling depends on STRICT.
   always_comb begin
      a_nxt   = 2'b00;
      en_nxt  = 1'b0;
      err_nxt = 1'b0;
      case (y_m)
         4'b0000: begin
            a_nxt  = 2'b00;
            en_nxt = 1'b0;
         end
         4'b0001: begin
            a_nxt  = 2'b00;
            en_nxt = 1'b1;
         end
         4'b0010: begin
            a_nxt  = 2'b01;
            en_nxt = 1'b1;
         end
         4'b0100: begin
            a_nxt  = 2'b10;
            en_nxt = 1'b1;
         end
         4'b1000: begin
            a_nxt  = 2'b11;
            en_nxt = 1'b1;
         end
         default: begin
            // Two or more bits set. In lenient mode the highest set bit wins.
            // Any multi-hot code has a set bit at index 1 or above.
            err_nxt = 1'b1;
            if (STRICT) begin
               a_nxt  = 2'b00;
               en_nxt = 1'b0;
            end else begin
               en_nxt = 1'b1;
               if (y_m[3])      a_nxt = 2'b11;
               else if (y_m[2]) a_nxt = 2'b10;
               else             a_nxt = 2'b01;
            end
         end
      endcase
   end

   // Output register: load on accept, drop valid on a consume with no new accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         a_out     <= 2'b00;
         en_out    <= 1'b0;
         err_out   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         a_out     <= a_nxt;
         en_out    <= en_nxt;
         err_out   <= err_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating error counter. It counts on accept, and a clear wins over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt <= '0;
      end else if (accept && err_nxt && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule
